one_bit_reg: RTL and testbench
==============================

// Module: one_bit_reg
// PURPOSE
//   Single-bit storage element with load enable and asynchronous active-low reset.
//   Basic building block for wider registers, status flags and control bits in the
//   RISC-V datapath (PC, register file and pipeline registers are built from it).
//   Adds a "loaded since reset" indicator and, optionally, edge-detect pulses.
// PARAMETERS
//   RESET_VALUE  1'b0  value forced onto data_out while reset is asserted
// PORTS
//   clk       input   1  clock; all state updates on rising edge
//   reset     input   1  asynchronous, active-low reset (0 = reset asserted)
//   load      input   1  write enable; sampled on rising clk edge
//   data_in   input   1  data to store when load=1
//   data_out  output  1  stored bit, registered
//   loaded    output  1  1 once a load has been accepted since the last reset
//   rise      output  1  (ONE_BIT_REG_EDGE_DETECT_EN only) one-cycle 0->1 pulse
//   fall      output  1  (ONE_BIT_REG_EDGE_DETECT_EN only) one-cycle 1->0 pulse
// BEHAVIOUR
//   - reset=0: data_out<=RESET_VALUE, loaded<=0, rise<=0, fall<=0 immediately,
//     independent of clk; held for as long as reset=0.
//   - Reset deassertion (0->1) takes effect at the next rising clk edge; no
//     load is accepted on an edge where reset=0.
//   - Rising clk, reset=1, load=1: data_out<=data_in, loaded<=1. Latency 1 cycle:
//     the new value is visible right after the edge.
//   - Rising clk, reset=1, load=0: data_out, loaded hold their values.
//   - Falling clk edges and data_in/load changes between edges have no effect.
//   - Loading the same value as currently stored is legal; data_out unchanged,
//     loaded still becomes 1.
//   - Reset mid-operation overrides any pending load; loaded returns to 0.
//   - X/Z on data_in with load=1 propagates to data_out (no masking).
// CONFIGURATION
//   Macro ONE_BIT_REG_EDGE_DETECT_EN:
//   - Defined: rise/fall ports exist. On a load edge, rise=1 for exactly one cycle
//     if data_out goes 0->1, fall=1 for one cycle if it goes 1->0; otherwise both 0.
//     Both registered, cleared by reset, never simultaneously 1.
//   - Undefined: rise/fall ports absent; no extra flops; all other behaviour identical.
// TESTING
//   1. reset=0 with clk running, load=1, data_in=1 -> data_out=RESET_VALUE (0),
//      loaded=0 throughout.
//   2. reset=1, load=1, data_in=1, rising clk -> data_out=1, loaded=1; next edge
//      load=0, data_in=0 -> data_out stays 1.
//   3. data_out=1, load=1, data_in=0, rising clk -> data_out=0; toggle data_in with
//      load=0 over 3 edges -> data_out stays 0.
//   4. data_out=1, drop reset to 0 between clock edges -> data_out=0, loaded=0
//      before the next rising edge; release reset, load=0 -> data_out stays 0.
//   5. data_in changes while clk=1 (no edge), load=1 -> data_out unchanged until
//      the next rising edge.
//   6. EDGE_DETECT_EN: load 0->1 -> rise=1 for one cycle, fall=0; load 1->0 ->
//      fall=1 for one cycle; reload 0 with data_out=0 -> both stay 0.

Source files
------------

// File: rtl/one_bit_reg_if.sv
// Signal bundle for one_bit_reg: load/data into the bit, stored value and status out.
// rise/fall are present only when ONE_BIT_REG_EDGE_DETECT_EN is defined.
interface one_bit_reg_if;
    logic load;
    logic data_in;
    logic data_out;
    logic loaded;
`ifdef ONE_BIT_REG_EDGE_DETECT_EN
    logic rise;
    logic fall;

    modport master (output load, output data_in,
                    input data_out, input loaded, input rise, input fall);
    modport slave  (input load, input data_in,
                    output data_out, output loaded, output rise, output fall);
`else
    modport master (output load, output data_in,
                    input data_out, input loaded);
    modport slave  (input load, input data_in,
                    output data_out, output loaded);
`endif
endinterface

// File: rtl/one_bit_reg.sv
// Single-bit register with load enable, async active-low reset and a loaded-since-reset flag.
// Define ONE_BIT_REG_EDGE_DETECT_EN to add registered rise/fall pulses on load edges.
module one_bit_reg #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    one_bit_reg_if.slave   bus
);

    logic data_q;
    logic loaded_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q   <= RESET_VALUE;
            loaded_q <= 1'b0;
        end else if (bus.load) begin
            data_q   <= bus.data_in;
            loaded_q <= 1'b1;
        end
    end

    assign bus.data_out = data_q;
    assign bus.loaded   = loaded_q;

`ifdef ONE_BIT_REG_EDGE_DETECT_EN
    logic rise_q;
    logic fall_q;

    // Pulses compare the incoming value against the one being replaced, so a
    // same-value reload or an idle cycle drives both low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= bus.load & ~data_q &  bus.data_in;
            fall_q <= bus.load &  data_q & ~bus.data_in;
        end
    end

    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
`endif

endmodule

// File: tb/tb_one_bit_reg.sv
// Directed-vector bench for one_bit_reg; outputs are sampled on the falling clock edge.
module tb_one_bit_reg;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    one_bit_reg_if bus ();

    one_bit_reg #(.RESET_VALUE(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b0;
        bus.load    = 1'b1;
        bus.data_in = 1'b1;

        // Reset held with a pending load: nothing gets through.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_data", bus.data_out, 1'b0);
            chk("rst_loaded", bus.loaded, 1'b0);
`ifdef ONE_BIT_REG_EDGE_DETECT_EN
            chk("rst_rise", bus.rise, 1'b0);
            chk("rst_fall", bus.fall, 1'b0);
`endif
        end

        // Release; first edge accepts the load.
        reset = 1'b1;
        step();
        chk("load1_data", bus.data_out, 1'b1);
        chk("load1_loaded", bus.loaded, 1'b1);
        bus.load    = 1'b0;
        bus.data_in = 1'b0;
        step();
        chk("hold1_data", bus.data_out, 1'b1);
        chk("hold1_loaded", bus.loaded, 1'b1);

        // Load 0, then wiggle data_in without load.
        bus.load = 1'b1;
        step();
        chk("load0_data", bus.data_out, 1'b0);
        bus.load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.data_in = ~bus.data_in;
            step();
            chk("hold0_data", bus.data_out, 1'b0);
            chk("hold0_loaded", bus.loaded, 1'b1);
        end

        // Async reset between edges.
        bus.load    = 1'b1;
        bus.data_in = 1'b1;
        step();
        chk("pre_rst_data", bus.data_out, 1'b1);
        bus.load = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_data", bus.data_out, 1'b0);
        chk("async_rst_loaded", bus.loaded, 1'b0);
        #1 reset = 1'b1;
        step();
        chk("post_rst_data", bus.data_out, 1'b0);
        chk("post_rst_loaded", bus.loaded, 1'b0);

        // Input changes while clk is high take effect only at the next rise.
        @(posedge clk);
        #1;
        bus.load    = 1'b1;
        bus.data_in = 1'b1;
        #1;
        chk("mid_high_data", bus.data_out, 1'b0);
        @(negedge clk);
        chk("negedge_data", bus.data_out, 1'b0);
        chk("negedge_loaded", bus.loaded, 1'b0);
        step();
        chk("mid_load_data", bus.data_out, 1'b1);
        chk("mid_load_loaded", bus.loaded, 1'b1);

        // Same-value load after reset still sets loaded.
        reset = 1'b0;
        #1 reset = 1'b1;
        bus.load    = 1'b1;
        bus.data_in = 1'b0;
        step();
        chk("same_val_data", bus.data_out, 1'b0);
        chk("same_val_loaded", bus.loaded, 1'b1);

`ifdef ONE_BIT_REG_EDGE_DETECT_EN
        bus.data_in = 1'b1;
        step();
        chk("rise_pulse", bus.rise, 1'b1);
        chk("rise_nofall", bus.fall, 1'b0);
        bus.load = 1'b0;
        step();
        chk("rise_clear", bus.rise, 1'b0);
        bus.load    = 1'b1;
        bus.data_in = 1'b0;
        step();
        chk("fall_pulse", bus.fall, 1'b1);
        chk("fall_norise", bus.rise, 1'b0);
        step();
        chk("reload0_rise", bus.rise, 1'b0);
        chk("reload0_fall", bus.fall, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
